// File: rtl/scope_frame_pkg.sv
// Shared definitions for the scope capture frame format: state encoding,
// default sync bytes and length-field width, reused by the host-side parser.
package scope_frame_pkg;

  localparam int         LEN_WIDTH_DEF = 16;
  localparam logic [7:0] SYNC0_DEF     = 8'hA5;
  localparam logic [7:0] SYNC1_DEF     = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC0 = 3'd1,
    ST_SYNC1 = 3'd2,
    ST_LEN_H = 3'd3,
    ST_LEN_L = 3'd4,
    ST_DATA  = 3'd5,
    ST_CSUM  = 3'd6
  } frame_state_e;

endpackage

// File: rtl/scope_frame_reader.sv
// Drains frame_len samples from the prefetch FIFO read port and emits them as
// a framed byte stream (sync, length, samples, mod-256 checksum) on valid/ready.
//
// state    | meaning
// ---------|----------------------------------------------------------------
// ST_IDLE  | waiting for start; output register empty
// ST_SYNC0 | next free slot of the output register gets SYNC0
// ST_SYNC1 | next free slot gets SYNC1
// ST_LEN_H | next free slot gets length high byte
// ST_LEN_L | next free slot gets length low byte
// ST_DATA  | popping samples straight into the output register
// ST_CSUM  | load checksum, then wait for its handshake before IDLE
module scope_frame_reader
  import scope_frame_pkg::*;
#(
  parameter int         LEN_WIDTH = LEN_WIDTH_DEF,
  parameter logic [7:0] SYNC0     = SYNC0_DEF,
  parameter logic [7:0] SYNC1     = SYNC1_DEF
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 abort,
  input  logic                 rd_vld,
  input  logic [7:0]           rd_data,
  output logic                 rd_en,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  frame_state_e         state_q, state_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;
  logic [7:0]           csum_q, csum_d;
  logic                 done_q, done_d;
  logic                 csum_sent_q, csum_sent_d;

  logic        free;
  logic        accept;
  logic [15:0] len_ext;

  // remain is untouched until DATA, so it still holds the latched length here
  assign len_ext = 16'(remain_q);

  always_comb begin
    free   = !out_valid_q || out_ready;
    accept = out_valid_q && out_ready;
    rd_en  = (state_q == ST_DATA) && rd_vld && free;

    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    remain_d    = remain_q;
    csum_d      = csum_q;
    done_d      = 1'b0;
    csum_sent_d = csum_sent_q;

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      remain_d    = '0;
      csum_sent_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_SYNC0;
            remain_d    = frame_len;
            csum_d      = 8'h00;
            csum_sent_d = 1'b0;
          end
        end
        ST_SYNC0: begin
          if (free) begin
            out_data_d  = SYNC0;
            out_valid_d = 1'b1;
            state_d     = ST_SYNC1;
          end
        end
        ST_SYNC1: begin
          if (free) begin
            out_data_d  = SYNC1;
            out_valid_d = 1'b1;
            state_d     = ST_LEN_H;
          end
        end
        ST_LEN_H: begin
          if (free) begin
            out_data_d  = len_ext[15:8];
            out_valid_d = 1'b1;
            state_d     = ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (free) begin
            out_data_d  = len_ext[7:0];
            out_valid_d = 1'b1;
            state_d     = (remain_q == '0) ? ST_CSUM : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rd_en) begin
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            csum_d      = csum_q + rd_data;
            if (remain_q != '0) remain_d = remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (!csum_sent_q) begin
            if (free) begin
              out_data_d  = csum_q;
              out_valid_d = 1'b1;
              csum_sent_d = 1'b1;
            end
          end else if (accept) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            csum_sent_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= ST_IDLE;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      remain_q    <= '0;
      csum_q      <= 8'h00;
      done_q      <= 1'b0;
      csum_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      remain_q    <= remain_d;
      csum_q      <= csum_d;
      done_q      <= done_d;
      csum_sent_q <= csum_sent_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule
